// File: rtl/div_issue_ctrl.sv
// Request front-end for the signed divider: accepts operands, pulses div_start, holds operands
// until the divider finishes and returns the result (or a divide-by-zero / watchdog status).
module div_issue_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [RES_W-1:0]  div_quotient,
  input  logic [RES_W-1:0]  div_remainder,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_quotient,
  output logic [RES_W-1:0]  rsp_remainder,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_dbz,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;

  // Timer counts cycles since the launch cycle, so the response lands TIMEOUT cycles after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      req_ready     <= 1'b1;
      div_start     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      rsp_valid     <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_tag       <= '0;
      rsp_dbz       <= 1'b0;
      rsp_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            div_a     <= req_a;
            div_b     <= req_b;
            rsp_tag   <= req_tag;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            timer_q   <= '0;
            if (req_b == '0) begin
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_dbz       <= 1'b1;
              rsp_timeout   <= 1'b0;
              rsp_valid     <= 1'b1;
              state_q       <= StResp;
            end else begin
              div_start <= 1'b1;
              state_q   <= StLaunch;
            end
          end
        end
        StLaunch: begin
          div_start <= 1'b0;
          timer_q   <= timer_q + 1'b1;
          state_q   <= StWait;
        end
        StWait: begin
          timer_q <= timer_q + 1'b1;
          // Completion wins over a coincident watchdog expiry.
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= 1'b1;
            state_q       <= StResp;
          end else if (timer_q == TimerMax) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: stub divider, transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_div_issue_ctrl;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int TW = 4;
  localparam int TO = 12;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [TW-1:0] req_tag;
  logic          div_start;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic          div_done;
  logic [RW-1:0] div_quotient;
  logic [RW-1:0] div_remainder;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_quotient;
  logic [RW-1:0] rsp_remainder;
  logic [TW-1:0] rsp_tag;
  logic          rsp_dbz;
  logic          rsp_timeout;
  logic          busy;

  div_issue_ctrl #(
    .DATA_W (DW),
    .RES_W  (RW),
    .TAG_W  (TW),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_tag      (rsp_tag),
    .rsp_dbz      (rsp_dbz),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Model state: one job at most, described by timestamps rather than states.
  int            cyc       = 0;
  bit            model_ok  = 0;
  bit            job       = 0;
  bit            rsp_known = 0;
  bit            m_in_wait = 0;
  int            launch    = -100;
  int            n_acc     = 0;
  int            n_starts  = 0;
  logic [DW-1:0] m_a, m_b;
  logic [TW-1:0] m_tag;
  logic [RW-1:0] m_q, m_r;
  bit            m_dbz, m_to;

  // Stub divider controls
  int stub_lat    = 1;
  bit stub_never  = 0;
  bit spurious_en = 0;
  bit force_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] sdiv_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int ia, ib, qq;
    ia = int'($signed(a));
    ib = int'($signed(b));
    qq = ia / ib;
    return qq[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] sdiv_r(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int ia, ib, rr;
    ia = int'($signed(a));
    ib = int'($signed(b));
    rr = ia % ib;
    return rr[RW-1:0];
  endfunction

  // Reference model: updated on each rising edge from the values of the cycle just ending.
  initial begin
    forever begin
      @(posedge clk);
      if (model_ok && div_start === 1'b1) n_starts++;
      cyc++;
      if (reset) begin
        model_ok  = 1;
        job       = 0;
        rsp_known = 0;
        launch    = -100;
        m_a = '0; m_b = '0; m_tag = '0; m_q = '0; m_r = '0; m_dbz = 0; m_to = 0;
      end else if (!job) begin
        if (req_valid) begin
          job   = 1;
          n_acc++;
          m_a   = req_a;
          m_b   = req_b;
          m_tag = req_tag;
          if (req_b == '0) begin
            rsp_known = 1;
            m_q = '0; m_r = '0; m_dbz = 1; m_to = 0;
          end else begin
            rsp_known = 0;
            launch    = cyc;
          end
        end
      end else if (!rsp_known) begin
        if (cyc - 1 > launch) begin
          if (div_done) begin
            rsp_known = 1;
            m_q = sdiv_q(m_a, m_b); m_r = sdiv_r(m_a, m_b); m_dbz = 0; m_to = 0;
          end else if (cyc - 1 - launch == TO - 1) begin
            rsp_known = 1;
            m_q = '0; m_r = '0; m_dbz = 0; m_to = 1;
          end
        end
      end else if (rsp_ready) begin
        job = 0;
      end
      m_in_wait = job && !rsp_known && (cyc > launch);
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("busy", 32'(busy), 32'(job));
        chk("req_ready", 32'(req_ready), 32'(!job));
        chk("div_start", 32'(div_start), 32'(job && !rsp_known && cyc == launch));
        chk("rsp_valid", 32'(rsp_valid), 32'(job && rsp_known));
        chk("div_a", 32'(div_a), 32'(m_a));
        chk("div_b", 32'(div_b), 32'(m_b));
        chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
        if (job && rsp_known) begin
          chk("rsp_quotient", 32'(rsp_quotient), 32'(m_q));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(m_r));
          chk("rsp_dbz", 32'(rsp_dbz), 32'(m_dbz));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        end
      end
    end
  end

  // Stub divider: done pulse stub_lat cycles after div_start, plus optional stray pulses.
  initial begin
    int cnt;
    cnt           = 0;
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    forever begin
      @(posedge clk);
      #2;
      div_done = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (div_start === 1'b1) begin
        cnt = stub_never ? 0 : stub_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done      = 1'b1;
          div_quotient  = sdiv_q(div_a, div_b);
          div_remainder = sdiv_r(div_a, div_b);
        end
      end else if (force_done || (spurious_en && !m_in_wait && $urandom_range(0, 5) == 0)) begin
        div_done      = 1'b1;
        div_quotient  = RW'($urandom);
        div_remainder = RW'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int a0;
    bit got;
    got       = 0;
    a0        = n_acc;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (n_acc != a0) begin
        got = 1;
        break;
      end
    end
    req_valid = 1'b0;
    chk("accepted", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(output int w);
    w = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) break;
      step();
      w++;
    end
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int w, s0, a0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_q", 32'(rsp_quotient), 32'd0);
    reset = 1'b0;

    // 100 / 7
    stub_lat = 5;
    s0 = n_starts;
    send(8'd100, 8'd7, 4'd3);
    wait_rsp(w);
    chk("t1_latency", 32'(w), 32'd6);
    chk("t1_q", 32'(rsp_quotient), 32'd14);
    chk("t1_r", 32'(rsp_remainder), 32'd2);
    chk("t1_tag", 32'(rsp_tag), 32'd3);
    chk("t1_dbz", 32'(rsp_dbz), 32'd0);
    chk("t1_timeout", 32'(rsp_timeout), 32'd0);
    chk("t1_starts", 32'(n_starts - s0), 32'd1);
    ack();

    // -128 / 1
    stub_lat = 3;
    send(8'h80, 8'd1, 4'd5);
    wait_rsp(w);
    chk("t2_q", 32'(rsp_quotient), 32'h0000ff80);
    chk("t2_r", 32'(rsp_remainder), 32'd0);
    chk("t2_tag", 32'(rsp_tag), 32'd5);
    ack();

    // 55 / 0
    s0 = n_starts;
    send(8'd55, 8'd0, 4'd9);
    wait_rsp(w);
    chk("t3_latency", 32'(w), 32'd0);
    chk("t3_q", 32'(rsp_quotient), 32'd0);
    chk("t3_dbz", 32'(rsp_dbz), 32'd1);
    chk("t3_tag", 32'(rsp_tag), 32'd9);
    ack();
    step();
    chk("t3_no_start", 32'(n_starts - s0), 32'd0);

    // Divider never answers; a late done during the response is ignored
    stub_never = 1;
    send(8'd1, 8'd1, 4'd2);
    wait_rsp(w);
    chk("t4_latency", 32'(w), 32'(TO));
    chk("t4_timeout", 32'(rsp_timeout), 32'd1);
    chk("t4_q", 32'(rsp_quotient), 32'd0);
    force_done = 1;
    step();
    force_done = 0;
    repeat (2) step();
    chk("t4_timeout_held", 32'(rsp_timeout), 32'd1);
    chk("t4_r_held", 32'(rsp_remainder), 32'd0);
    ack();
    stub_never = 0;

    // Response backpressure with a second request waiting
    stub_lat = 2;
    send(8'd20, 8'd3, 4'd7);
    wait_rsp(w);
    chk("t5_q", 32'(rsp_quotient), 32'd6);
    req_a = 8'd9; req_b = 8'd2; req_tag = 4'd8; req_valid = 1'b1;
    a0 = n_acc;
    repeat (10) step();
    chk("t5_no_accept", 32'(n_acc - a0), 32'd0);
    chk("t5_req_ready_bp", 32'(req_ready), 32'd0);
    chk("t5_q_held", 32'(rsp_quotient), 32'd6);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t5_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    step();
    chk("t5_accept", 32'(n_acc - a0), 32'd1);
    req_valid = 1'b0;
    wait_rsp(w);
    chk("t5_q2", 32'(rsp_quotient), 32'd4);
    chk("t5_r2", 32'(rsp_remainder), 32'd1);
    chk("t5_tag2", 32'(rsp_tag), 32'd8);
    ack();

    // Reset while waiting on the divider
    stub_lat = 20;
    send(8'd100, 8'd7, 4'd1);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_div_start", 32'(div_start), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    stub_lat = 3;
    send(8'd100, 8'd7, 4'd4);
    wait_rsp(w);
    chk("t6_q", 32'(rsp_quotient), 32'd14);
    chk("t6_r", 32'(rsp_remainder), 32'd2);
    chk("t6_tag", 32'(rsp_tag), 32'd4);
    ack();

    // Randomized traffic
    spurious_en = 1;
    repeat (3000) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_a      = DW'($urandom);
      req_b      = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      req_tag    = TW'($urandom);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 299) == 0);
      stub_lat   = $urandom_range(1, TO + 3);
      stub_never = ($urandom_range(0, 7) == 0);
      step();
    end
    reset       = 1'b0;
    req_valid   = 1'b0;
    spurious_en = 0;
    rsp_ready   = 1'b1;
    repeat (TO + 5) step();
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
